stopwatch_ctrl: RTL and testbench

//  Control FSM for the mm:ss stopwatch datapath. Turns two raw push-buttons (start/stop, lap/reset)

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/btn_debounce.sv | 48 ++++
 rtl/stopwatch_ctrl.sv | 136 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch control slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } sw_state_t;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned DEBOUNCE_MS = 20;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser plus stability-counter debouncer; emits a one-cycle pulse on an accepted press.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   stable_q;
  logic                   press_q;
  logic                   synced;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign press_o = press_q;

  // The pulse is raised on the same edge that accepts a new high level, so it is already registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
      press_q <= 1'b0;
      if (synced == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= synced;
        cnt_q    <= '0;
        press_q  <= synced;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced buttons, run/pause/lap FSM, 1 Hz prescaler and counter strobes.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV        = CLK_HZ,
  parameter int unsigned DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop_btn,
  input  logic       lap_reset_btn,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_hold,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned   PW         = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic          ss_p;
  logic          lr_p;
  sw_state_t     state_q;
  logic [PW-1:0] presc_q;
  logic          tick_q;
  logic          cnt_en_q;
  logic          cnt_clr_q;
  logic          lap_hold_q;
  logic          running_q;
  logic          counting;
  logic          wrap;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_ss_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (start_stop_btn),
    .press_o(ss_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_lr_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (lap_reset_btn),
    .press_o(lr_p)
  );

  assign counting = (state_q == RUN) || (state_q == LAP);
  assign wrap     = counting && (presc_q == PRESC_LAST);

  assign cnt_en   = cnt_en_q;
  assign cnt_clr  = cnt_clr_q;
  assign lap_hold = lap_hold_q;
  assign running  = running_q;
  assign state    = state_q;

  // Wrap is counted on the current state, so a wrap coinciding with a stop still yields its cnt_en;
  // a clear drops any tick still in flight so the two strobes never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      cnt_en_q   <= 1'b0;
      cnt_clr_q  <= 1'b0;
      lap_hold_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      tick_q    <= wrap;
      cnt_en_q  <= tick_q;
      cnt_clr_q <= 1'b0;
      if (wrap) begin
        presc_q <= '0;
      end else if (counting) begin
        presc_q <= presc_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (ss_p) begin
            state_q   <= RUN;
            running_q <= 1'b1;
            presc_q   <= '0;
          end else if (lr_p) begin
            cnt_clr_q <= 1'b1;
            cnt_en_q  <= 1'b0;
          end
        end
        RUN: begin
          if (ss_p) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end else if (lr_p) begin
            state_q    <= LAP;
            lap_hold_q <= 1'b1;
          end
        end
        LAP: begin
          if (ss_p) begin
            state_q    <= PAUSE;
            running_q  <= 1'b0;
            lap_hold_q <= 1'b0;
          end else if (lr_p) begin
            state_q    <= RUN;
            lap_hold_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (ss_p) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end else if (lr_p) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            cnt_clr_q <= 1'b1;
            cnt_en_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          presc_q    <= '0;
          running_q  <= 1'b0;
          lap_hold_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DEBOUNCE_CYCLES=3, SYNC_STAGES=2.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ss_btn;
  logic       lr_btn;
  logic       cnt_en;
  logic       cnt_clr;
  logic       lap_hold;
  logic       running;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;
  int en_base  = 0;
  int clr_t    = -1;
  int run_r    = 0;
  bit cad_on   = 1'b0;
  int p        = 0;

  stopwatch_ctrl #(
    .TICK_DIV       (4),
    .DEBOUNCE_CYCLES(3),
    .SYNC_STAGES    (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_stop_btn(ss_btn),
    .lap_reset_btn (lr_btn),
    .cnt_en        (cnt_en),
    .cnt_clr       (cnt_clr),
    .lap_hold      (lap_hold),
    .running       (running),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h (step %0d)", tag, obs, expv, t);
    end
  endtask

  // One clock step, sampled 1 time unit after the edge; cnt_clr is always checked,
  // cnt_en only while a tick cadence is armed (first tick at en_base, then every 4th step).
  task automatic step();
    @(posedge clk);
    #1;
    t++;
    check("cnt_clr", {1'b0, cnt_clr}, (t == clr_t) ? 2'd1 : 2'd0);
    if (cad_on)
      check("cnt_en_cadence", {1'b0, cnt_en},
            (t >= en_base && (t - en_base) % 4 == 0) ? 2'd1 : 2'd0);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Holds the selected buttons for 4 steps, then one more step: returns at press+5.
  task automatic tap(input logic ss, input logic lr);
    ss_btn = ss;
    lr_btn = lr;
    steps(4);
    ss_btn = 1'b0;
    lr_btn = 1'b0;
    step();
  endtask

  initial begin
    // Reset with both buttons held
    rst_n  = 1'b0;
    ss_btn = 1'b1;
    lr_btn = 1'b1;
    steps(3);
    check("rst_state",    state,              2'b00);
    check("rst_running",  {1'b0, running},    2'd0);
    check("rst_lap_hold", {1'b0, lap_hold},   2'd0);
    check("rst_cnt_en",   {1'b0, cnt_en},     2'd0);
    ss_btn = 1'b0;
    lr_btn = 1'b0;
    steps(2);
    rst_n = 1'b1;
    steps(10);
    check("idle_state",   state,              2'b00);
    check("idle_running", {1'b0, running},    2'd0);
    check("idle_cnt_en",  {1'b0, cnt_en},     2'd0);

    // Start: held 10 cycles, RUN six clocks after the input edge, first tick 5 after entry
    p       = t;
    ss_btn  = 1'b1;
    en_base = p + 11;
    cad_on  = 1'b1;
    steps(5);
    check("start_not_yet", state, 2'b00);
    step();
    run_r = t;
    check("start_run",     state,           2'b01);
    check("start_running", {1'b0, running}, 2'd1);
    steps(4);
    ss_btn = 1'b0;
    steps(9);
    check("release_no_effect", state, 2'b01);

    // Bounce on start/stop: two-cycle pulses never pass the debouncer
    repeat (3) begin
      ss_btn = 1'b1;
      steps(2);
      ss_btn = 1'b0;
      steps(2);
    end
    steps(6);
    check("bounce_state",   state,           2'b01);
    check("bounce_running", {1'b0, running}, 2'd1);

    // Lap in and out while the tick cadence keeps running
    tap(1'b0, 1'b1);
    check("lap_not_yet", state, 2'b01);
    step();
    check("lap_state",    state,            2'b11);
    check("lap_hold_on",  {1'b0, lap_hold}, 2'd1);
    check("lap_running",  {1'b0, running},  2'd1);
    steps(6);
    tap(1'b0, 1'b1);
    step();
    check("unlap_state",    state,            2'b01);
    check("unlap_hold_off", {1'b0, lap_hold}, 2'd0);
    steps(6);

    // Stop with the prescaler at 2 in the pulse cycle; it then holds at 3
    while ((t - run_r) % 4 != 1) step();
    tap(1'b1, 1'b0);
    check("stop_not_yet", state, 2'b01);
    step();
    cad_on = 1'b0;
    check("stop_state",   state,           2'b10);
    check("stop_running", {1'b0, running}, 2'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("pause_no_cnt_en", {1'b0, cnt_en}, 2'd0);
    end

    // Resume: held value 3 wraps on the first RUN edge, tick 2 clocks after entry
    en_base = t + 8;
    cad_on  = 1'b1;
    tap(1'b1, 1'b0);
    check("resume_not_yet", state, 2'b10);
    step();
    run_r = t;
    check("resume_state", state, 2'b01);
    steps(4);

    // Stop one edge after a wrap: the pending tick still appears, prescaler holds 1
    while ((t - run_r) % 4 != 0) step();
    tap(1'b1, 1'b0);
    step();
    cad_on = 1'b0;
    check("stop2_state",  state,          2'b10);
    check("stop2_cnt_en", {1'b0, cnt_en}, 2'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("pause2_no_cnt_en", {1'b0, cnt_en}, 2'd0);
    end

    // Clear from PAUSE: one cnt_clr cycle and the prescaler returns to 0
    clr_t = t + 6;
    tap(1'b0, 1'b1);
    check("clr_not_yet", state, 2'b10);
    step();
    check("clr_state",   state,           2'b00);
    check("clr_pulse",   {1'b0, cnt_clr}, 2'd1);
    check("clr_running", {1'b0, running}, 2'd0);
    steps(6);

    // Fresh RUN: first tick 5 after entry proves the prescaler was cleared
    en_base = t + 11;
    cad_on  = 1'b1;
    tap(1'b1, 1'b0);
    step();
    check("rerun_state", state, 2'b01);
    steps(6);

    // Both buttons in the same cycle: start/stop wins, lap request dropped
    cad_on = 1'b0;
    tap(1'b1, 1'b1);
    step();
    check("both_state",    state,            2'b10);
    check("both_lap_hold", {1'b0, lap_hold}, 2'd0);
    steps(4);
    check("both_settled",  state,            2'b10);
    check("both_lap_hold2", {1'b0, lap_hold}, 2'd0);
    steps(4);

    // Asynchronous reset while running drops the outputs before the next edge
    tap(1'b1, 1'b0);
    step();
    check("prerst_state", state, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state",   state,           2'b00);
    check("async_rst_running", {1'b0, running}, 2'd0);
    check("async_rst_cnt_en",  {1'b0, cnt_en},  2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
